// File: rtl/tea_pkg.sv
// Shared TEA definitions: constants, FSM encodings, key-word selection and round mix.
package tea_pkg;

  localparam int unsigned WORD_W             = 32;
  localparam int unsigned BLOCK_W            = 64;
  localparam int unsigned KEY_W              = 128;
  localparam int unsigned TEA_ROUNDS_DEFAULT = 32;

  localparam logic [WORD_W-1:0] TEA_DELTA = 32'h9E3779B9;

  // FSM encodings, shared with the encryption engine
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  // Key word indices; k0 sits in the most significant word
  localparam logic [1:0] K0 = 2'd0;
  localparam logic [1:0] K1 = 2'd1;
  localparam logic [1:0] K2 = 2'd2;
  localparam logic [1:0] K3 = 2'd3;

  // Select one 32-bit key word by index
  function automatic logic [WORD_W-1:0] key_word(input logic [KEY_W-1:0] key,
                                                 input logic [1:0]       idx);
    logic [WORD_W-1:0] w;
    case (idx)
      K0:      w = key[127:96];
      K1:      w = key[95:64];
      K2:      w = key[63:32];
      default: w = key[31:0];
    endcase
    return w;
  endfunction

  // TEA Feistel mix term: ((v<<4)+ka) ^ (v+sum) ^ ((v>>5)+kb), all mod 2^32
  function automatic logic [WORD_W-1:0] tea_mix(input logic [WORD_W-1:0] v,
                                                input logic [WORD_W-1:0] sum,
                                                input logic [WORD_W-1:0] ka,
                                                input logic [WORD_W-1:0] kb);
    return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_dec_round.sv
// One combinational TEA decryption round: undo z first, then y using the new z.
module tea_dec_round
  import tea_pkg::*;
(
  input  logic [31:0]  y,
  input  logic [31:0]  z,
  input  logic [31:0]  sum,
  input  logic [127:0] key,
  output logic [31:0]  y_next,
  output logic [31:0]  z_next
);

  // Inverse of the encryption half-rounds, applied in reverse order
  always_comb begin
    z_next = z - tea_mix(y, sum, key_word(key, K2), key_word(key, K3));
    y_next = y - tea_mix(z_next, sum, key_word(key, K0), key_word(key, K1));
  end

endmodule

// File: rtl/tea_dec.sv
// Iterative TEA decryption core, one round per clock.
// Optional build macro: TEA_DEC_ABORT_EN adds an abort input that cancels a run.
module tea_dec
  import tea_pkg::*;
#(
  parameter int unsigned ROUNDS = TEA_ROUNDS_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  data,
  input  logic [127:0] key,
  input  logic [31:0]  delta,
  input  logic         ready,
`ifdef TEA_DEC_ABORT_EN
  input  logic         abort,
`endif
  output logic         done,
  output logic         work_in_progress,
  output logic [63:0]  decrypted_data
);

  localparam int unsigned CNT_W = 7;

  logic [1:0]         state_q, state_d;
  logic [WORD_W-1:0]  y_q, y_d, z_q, z_d, sum_q, sum_d, delta_q, delta_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d, wip_q, wip_d;
  logic [BLOCK_W-1:0] out_q, out_d;
  logic [WORD_W-1:0]  y_next, z_next;
  logic               start_c;
  logic               abort_c;

  tea_dec_round u_round (
    .y      (y_q),
    .z      (z_q),
    .sum    (sum_q),
    .key    (key_q),
    .y_next (y_next),
    .z_next (z_next)
  );

`ifdef TEA_DEC_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // abort beats ready when both are seen in IDLE
  assign start_c = ready & ~abort_c;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    z_d     = z_q;
    sum_d   = sum_q;
    delta_d = delta_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wip_d   = wip_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        wip_d = 1'b0;
        if (start_c) begin
          state_d = RUN;
          y_d     = data[63:32];
          z_d     = data[31:0];
          key_d   = key;
          delta_d = delta;
          sum_d   = delta * WORD_W'(ROUNDS);
          cnt_d   = '0;
          wip_d   = 1'b1;
        end
      end
      RUN: begin
        if (abort_c) begin
          state_d = IDLE;
          wip_d   = 1'b0;
        end else begin
          y_d   = y_next;
          z_d   = z_next;
          sum_d = sum_q - delta_q;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ROUNDS - 1)) begin
            state_d = FINISH;
            wip_d   = 1'b0;
          end
        end
      end
      FINISH: begin
        out_d   = {y_q, z_q};
        done_d  = 1'b1;
        wip_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        wip_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      z_q     <= '0;
      sum_q   <= '0;
      delta_q <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      wip_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      z_q     <= z_d;
      sum_q   <= sum_d;
      delta_q <= delta_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      wip_q   <= wip_d;
      out_q   <= out_d;
    end
  end

  assign done             = done_q;
  assign work_in_progress = wip_q;
  assign decrypted_data   = out_q;

endmodule

// File: doc/tea_dec.md
Name: tea_dec

Overview:
- Iterative TEA decryption core; the inverse of the TEA_en encryption engine.
- Accepts a 64-bit ciphertext block, a 128-bit key and a delta constant.
- Runs ROUNDS decryption rounds, one full round per clock, and presents the 64-bit plaintext with a one-cycle done pulse.
- Sits beside TEA_en in the crypto datapath and uses the same ready/done/work_in_progress handshake.

Parameters:
- ROUNDS, 32, number of TEA cycles; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- data  input  64  ciphertext; y=data[63:32], z=data[31:0].
- key  input  128  k0=key[127:96], k1=key[95:64], k2=key[63:32], k3=key[31:0].
- delta  input  32  round constant (nominal 32'h9E3779B9).
- ready  input  1  start request; sampled only in IDLE.
- done  output  1  one-cycle pulse when decrypted_data is valid.
- work_in_progress  output  1  high while rounds are executing.
- decrypted_data  output  64  plaintext {y,z}; held until the next completion.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; done=0; work_in_progress=0; decrypted_data=0; y, z, sum, round counter, and latched key/delta cleared.
- FSM states: IDLE, RUN, FINISH.
- IDLE -> RUN on a clk edge with ready=1:
  - latch y, z, key and delta;
  - sum = delta*ROUNDS, truncated to 32 bits (for ROUNDS=32 this is delta<<5, i.e. 32'hC6EF3720 for the nominal delta);
  - counter = 0.
- RUN: each clk performs one round on the latched values, all mod 2^32:
  - z -= ((y<<4)+k2) ^ (y+sum) ^ ((y>>5)+k3)
  - y -= ((z_new<<4)+k0) ^ (z_new+sum) ^ ((z_new>>5)+k1)
  - sum -= delta
  - counter++
  - work_in_progress=1 throughout RUN.
- Shifts are logical; all adders and subtractors are 32 bits with carries and borrows discarded.
- RUN -> FINISH when counter reaches ROUNDS-1 on that edge, i.e. after exactly ROUNDS round updates.
- FINISH: decrypted_data={y,z}; done=1 for exactly one cycle; work_in_progress=0; next state IDLE.
- Latency: ready sampled at edge N -> done high during cycle N+ROUNDS+1. Back-to-back starts are possible every ROUNDS+2 cycles.
- ready in RUN or FINISH is ignored; no queueing.
- data, key and delta changes after the start edge do not affect the operation in flight.
- After the final round, sum equals 0. This is checkable via hierarchical probe.
- Reset asserted mid-operation aborts immediately; no done pulse; decrypted_data returns to 0.
- ready held high continuously: a new operation starts on each return to IDLE.

Optional Feature:
- Macro: TEA_DEC_ABORT_EN.
- Defined:
  - adds input port abort (1 bit);
  - abort=1 in RUN -> IDLE at the next edge, with work_in_progress=0, no done pulse, and decrypted_data unchanged;
  - abort in IDLE or FINISH is ignored;
  - abort and ready together in IDLE: abort wins and no start occurs.
- Undefined: the port is absent and the operation always runs to completion.

Decomposition:
- Package tea_pkg:
  - TEA_DELTA=32'h9E3779B9;
  - TEA_ROUNDS_DEFAULT=32;
  - state enum {IDLE,RUN,FINISH};
  - key-word index constants K0..K3;
  - shared with TEA_en.
- Sub-module tea_dec_round: purely combinational single round (inputs y, z, sum, key; outputs y_next, z_next). It is instanced once in tea_dec and independently unit-testable.

Test Plan:
- Known vector: key=0, delta=9E3779B9, data=64'h41EA3A0A_94BAA940, ready pulse -> done after 33 cycles, decrypted_data=64'h0; work_in_progress high for exactly 32 cycles.
- Round trip: data=5, key=128'h95b3a17446cf51e1d8c4f6b493a71922 through TEA_en, its encrypted_data into tea_dec -> decrypted_data=64'h0000000000000005.
- Mid-run reset: start, drop rst low at round 10 -> outputs 0 immediately, no done; a restart after release yields the correct result.
- Busy ignore: ready re-pulsed with different data at rounds 5 and 20 -> single done with the first block's plaintext; the next start only after returning to IDLE.
- Input hold: change data/key/delta during RUN -> result unchanged vs the golden model.
- TEA_DEC_ABORT_EN build: abort at round 7 -> IDLE next cycle, done never asserted, decrypted_data keeps its previous value; a new start completes correctly.
